// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared constants, state encoding and frame layout for the command sequencer
package uart_cmd_pkg;

  localparam int FRAME_W  = 128;
  localparam int TIMER_W  = 24;
  localparam int BYTE_W   = 8;
  localparam int WORD_W   = 32;

  // Frame field positions; everything above USED_W is payload the sequencer never looks at
  localparam int OPC_LSB  = 0;
  localparam int SEQ_LSB  = 8;
  localparam int IDX_LSB  = 16;
  localparam int DATA_LSB = 24;
  localparam int USED_W   = DATA_LSB + WORD_W;

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_WRITE_CFG = 8'h01;
  localparam logic [7:0] OP_RUN       = 8'h02;
  localparam logic [7:0] OP_DUT_RESET = 8'h03;

  localparam logic [7:0] ST_OK         = 8'h00;
  localparam logic [7:0] ST_BAD_OPCODE = 8'h01;
  localparam logic [7:0] ST_BAD_INDEX  = 8'h02;
  localparam logic [7:0] ST_TIMEOUT    = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_RUN_START,
    S_RUN_WAIT,
    S_RST_HOLD,
    S_REPORT
  } state_t;

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// rtl/uart_cmd_sequencer_if.sv - receiver frame handshake between the UART receiver and the sequencer
interface uart_cmd_sequencer_if;
  import uart_cmd_pkg::*;

  logic               FRAME_READY;
  logic [FRAME_W-1:0] FRAME;
  logic               FRAME_ACK;

  modport master (output FRAME_READY, output FRAME, input FRAME_ACK);
  modport slave  (input FRAME_READY, input FRAME, output FRAME_ACK);

endinterface

// File: rtl/seq_timer.sv
// rtl/seq_timer.sv - loadable down-counter shared by the run timeout and the DUT reset hold
module seq_timer
  import uart_cmd_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               load,
  input  logic               en,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expire
);

  logic [TIMER_W-1:0] count;

  // Reload on request, otherwise count down while enabled until empty
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

  // Fires on the last enabled cycle of the loaded interval
  assign expire = en && (count == TIMER_W'(1));

endmodule

// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - decodes received frames and sequences config writes, DUT runs and DUT resets
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter int NUM_CFG        = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int DUT_RST_CYCLES = 100
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  uart_cmd_sequencer_if.slave       rx,
  output logic [WORD_W*NUM_CFG-1:0] CFG,
  output logic                      DUT_START,
  input  logic                      DUT_DONE,
  output logic                      DUT_RST_N,
  output logic                      BUSY,
  output logic [7:0]                STATUS,
  output logic [7:0]                LAST_SEQ,
  output logic                      STATUS_VALID
);

  state_t                         state, state_next;
  logic [USED_W-1:0]              frame_q;
  logic [BYTE_W-1:0]              opcode, seq, index;
  logic [WORD_W-1:0]              data_word;
  logic [7:0]                     status_q, status_next;
  logic [NUM_CFG-1:0][WORD_W-1:0] cfg_q;
  logic                           cfg_we, index_ok, capture, frame_ack_q;
  logic                           timer_load, timer_en, timer_expire;
  logic [TIMER_W-1:0]             timer_val;
  logic                           start_next, dut_rst_n_next;
  logic                           unused_frame_bits;

  assign capture   = (state == S_IDLE) && rx.FRAME_READY;
  assign opcode    = frame_q[OPC_LSB  +: BYTE_W];
  assign seq       = frame_q[SEQ_LSB  +: BYTE_W];
  assign index     = frame_q[IDX_LSB  +: BYTE_W];
  assign data_word = frame_q[DATA_LSB +: WORD_W];
  assign index_ok  = ({1'b0, index} < 9'(NUM_CFG));
  assign unused_frame_bits = ^rx.FRAME[FRAME_W-1:USED_W];

  assign CFG          = cfg_q;
  assign rx.FRAME_ACK = frame_ack_q;

  seq_timer u_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (timer_val),
    .expire   (timer_expire)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode, command dispatch and timer control
  always_comb begin
    state_next     = state;
    status_next    = status_q;
    cfg_we         = 1'b0;
    timer_load     = 1'b0;
    timer_en       = 1'b0;
    timer_val      = '0;
    start_next     = 1'b0;
    dut_rst_n_next = 1'b1;
    case (state)
      S_IDLE: begin
        if (rx.FRAME_READY) state_next = S_DECODE;
      end
      S_DECODE: begin
        state_next  = S_REPORT;
        status_next = ST_OK;
        case (opcode)
          OP_NOP:       status_next = ST_OK;
          OP_WRITE_CFG: begin
            if (index_ok) cfg_we = 1'b1;
            else          status_next = ST_BAD_INDEX;
          end
          OP_RUN: begin
            start_next = 1'b1;
            state_next = S_RUN_START;
          end
          OP_DUT_RESET: begin
            dut_rst_n_next = 1'b0;
            timer_load     = 1'b1;
            timer_val      = TIMER_W'(DUT_RST_CYCLES);
            state_next     = S_RST_HOLD;
          end
          default:      status_next = ST_BAD_OPCODE;
        endcase
      end
      S_RUN_START: begin
        // The start pulse is on the wire this cycle; the wait window begins next cycle
        timer_load = 1'b1;
        timer_val  = TIMER_W'(TIMEOUT_CYCLES);
        state_next = S_RUN_WAIT;
      end
      S_RUN_WAIT: begin
        timer_en = 1'b1;
        // A completion that coincides with expiry still counts as success
        if (DUT_DONE) begin
          status_next = ST_OK;
          state_next  = S_REPORT;
        end else if (timer_expire) begin
          status_next = ST_TIMEOUT;
          state_next  = S_REPORT;
        end
      end
      S_RST_HOLD: begin
        timer_en = 1'b1;
        if (timer_expire) begin
          status_next = ST_OK;
          state_next  = S_REPORT;
        end else begin
          dut_rst_n_next = 1'b0;
        end
      end
      S_REPORT: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Frame capture, config storage and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frame_q      <= '0;
      frame_ack_q  <= 1'b0;
      status_q     <= ST_OK;
      cfg_q        <= '0;
      DUT_START    <= 1'b0;
      DUT_RST_N    <= 1'b0;
      BUSY         <= 1'b0;
      STATUS       <= 8'h00;
      LAST_SEQ     <= 8'h00;
      STATUS_VALID <= 1'b0;
    end else begin
      if (capture) frame_q <= rx.FRAME[USED_W-1:0];
      frame_ack_q  <= capture;
      status_q     <= status_next;
      for (int i = 0; i < NUM_CFG; i++) begin
        if (cfg_we && (index == 8'(i))) cfg_q[i] <= data_word;
      end
      DUT_START    <= start_next;
      DUT_RST_N    <= dut_rst_n_next;
      BUSY         <= (state_next != S_IDLE);
      STATUS_VALID <= (state == S_REPORT);
      if (state == S_REPORT) begin
        STATUS   <= status_q;
        LAST_SEQ <= seq;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb/tb_uart_cmd_sequencer.sv - scoreboard bench for the command sequencer
module tb_uart_cmd_sequencer;

  localparam int NUM_CFG = 4;
  localparam int T       = 24;
  localparam int R       = 5;

  logic                   CLK = 1'b0;
  logic                   RST_N = 1'b0;
  logic                   DUT_DONE = 1'b0;
  logic [32*NUM_CFG-1:0]  CFG;
  logic                   DUT_START, DUT_RST_N, BUSY, STATUS_VALID;
  logic [7:0]             STATUS, LAST_SEQ;

  uart_cmd_sequencer_if rx();

  uart_cmd_sequencer #(
    .NUM_CFG        (NUM_CFG),
    .TIMEOUT_CYCLES (T),
    .DUT_RST_CYCLES (R)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .rx           (rx),
    .CFG          (CFG),
    .DUT_START    (DUT_START),
    .DUT_DONE     (DUT_DONE),
    .DUT_RST_N    (DUT_RST_N),
    .BUSY         (BUSY),
    .STATUS       (STATUS),
    .LAST_SEQ     (LAST_SEQ),
    .STATUS_VALID (STATUS_VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]   status;
    logic [7:0]   seq;
    logic [127:0] cfg;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model_cfg [NUM_CFG];

  int checks = 0, errors = 0;
  int cyc = 0, ack_cnt = 0, start_cnt = 0, rstlow_cnt = 0, sv_cnt = 0;
  int ack_cyc = 0, start_cyc = 0, sv_cyc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < NUM_CFG; i++) f[32*i +: 32] = model_cfg[i];
    return f;
  endfunction

  // Monitor: counts observed pulses and scores every status report against the queue
  always @(negedge CLK) begin
    cyc++;
    if (rx.FRAME_ACK) begin ack_cnt++; ack_cyc = cyc; end
    if (DUT_START) begin start_cnt++; start_cyc = cyc; end
    if (RST_N && !DUT_RST_N) rstlow_cnt++;
    if (STATUS_VALID) begin
      sv_cnt++;
      sv_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_status: got status %0h seq %0h, expected no report", STATUS, LAST_SEQ);
      end else begin
        mon_e = exp_q.pop_front();
        check("status", STATUS, mon_e.status);
        check("last_seq", LAST_SEQ, mon_e.seq);
        check("cfg", CFG, mon_e.cfg);
      end
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  // Reference model: status from the command rules; d is the DONE cycle counted from the start pulse
  task automatic expect_cmd(input logic [7:0] op, input logic [7:0] seq, input logic [7:0] idx,
                            input logic [31:0] data, input int d);
    exp_t e;
    case (op)
      8'h00: e.status = 8'h00;
      8'h01: begin
        if (int'(idx) < NUM_CFG) begin
          model_cfg[idx] = data;
          e.status = 8'h00;
        end else begin
          e.status = 8'h02;
        end
      end
      8'h02: e.status = (d >= 1 && d <= T) ? 8'h00 : 8'h03;
      8'h03: e.status = 8'h00;
      default: e.status = 8'h01;
    endcase
    e.seq = seq;
    e.cfg = model_flat();
    exp_q.push_back(e);
  endtask

  function automatic logic [127:0] make_frame(input logic [7:0] op, input logic [7:0] seq,
                                              input logic [7:0] idx, input logic [31:0] data);
    logic [127:0] f;
    f = {$urandom(), $urandom(), $urandom(), $urandom()};
    f[55:0] = {data, idx, seq, op};
    return f;
  endfunction

  task automatic present(input logic [7:0] op, input logic [7:0] seq, input logic [7:0] idx,
                         input logic [31:0] data);
    int base = ack_cnt;
    int n = 0;
    rx.FRAME = make_frame(op, seq, idx, data);
    rx.FRAME_READY = 1'b1;
    while (ack_cnt == base && n < 50) begin step(); n++; end
    rx.FRAME_READY = 1'b0;
    check("ack_received", (ack_cnt != base), 1);
  endtask

  task automatic wait_start(input int base);
    int n = 0;
    while (start_cnt == base && n < 10) begin step(); n++; end
    check("run_start_seen", (start_cnt != base), 1);
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [7:0] seq, input logic [7:0] idx,
                         input logic [31:0] data, input int d);
    int b_ack = ack_cnt, b_sv = sv_cnt, b_start = start_cnt, b_rl = rstlow_cnt;
    int n, exp_lat;
    expect_cmd(op, seq, idx, data, d);
    present(op, seq, idx, data);
    if (op == 8'h02) begin
      wait_start(b_start);
      n = 0;
      while (sv_cnt == b_sv && n < T + 10) begin
        DUT_DONE = (n == d);
        step();
        n++;
      end
      DUT_DONE = 1'b0;
      // pulse cycle, up to T sampled wait cycles, report cycle, then the status pulse
      exp_lat = (d >= 1 && d <= T) ? d + 2 : T + 2;
      check("run_latency", sv_cyc - start_cyc, exp_lat);
    end else begin
      n = 0;
      while (sv_cnt == b_sv && n < R + 20) begin step(); n++; end
      if (op != 8'h03) check("decode_latency", sv_cyc - ack_cyc, 2);
    end
    step();
    check("status_valid_count", sv_cnt - b_sv, 1);
    check("ack_count", ack_cnt - b_ack, 1);
    check("start_count", start_cnt - b_start, (op == 8'h02) ? 1 : 0);
    check("rst_low_cycles", rstlow_cnt - b_rl, (op == 8'h03) ? R : 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_frame_ack"}, rx.FRAME_ACK, 0);
    check({tag, "_cfg"}, CFG, 0);
    check({tag, "_dut_start"}, DUT_START, 0);
    check({tag, "_dut_rst_n"}, DUT_RST_N, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_status"}, STATUS, 0);
    check({tag, "_last_seq"}, LAST_SEQ, 0);
    check({tag, "_status_valid"}, STATUS_VALID, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_sv, b_ack, b_start, n;
    logic [7:0] op, idx;
    int d;

    rx.FRAME_READY = 1'b0;
    rx.FRAME = '0;
    for (int i = 0; i < NUM_CFG; i++) model_cfg[i] = '0;

    repeat (3) step();
    check_reset_outputs("reset");
    RST_N = 1'b1;
    step();
    check("dut_rst_n_release", DUT_RST_N, 1);
    check("cfg_after_release", CFG, 0);

    run_cmd(8'h01, 8'h11, 8'd2, 32'hDEADBEEF, 0);
    run_cmd(8'h01, 8'h12, 8'd4, 32'h12345678, 0);
    run_cmd(8'h7F, 8'h13, 8'd0, 32'h0, 0);
    run_cmd(8'h00, 8'h14, 8'd0, 32'h0, 0);
    for (int i = 0; i < NUM_CFG; i++) run_cmd(8'h01, 8'(8'h20 + i), 8'(i), $urandom(), 0);
    run_cmd(8'h02, 8'h30, 8'd0, 32'h0, 20);
    run_cmd(8'h02, 8'h31, 8'd0, 32'h0, 1000);
    run_cmd(8'h02, 8'h32, 8'd0, 32'h0, T);
    run_cmd(8'h02, 8'h33, 8'd0, 32'h0, T + 1);
    run_cmd(8'h02, 8'h34, 8'd0, 32'h0, 0);
    run_cmd(8'h02, 8'h35, 8'd0, 32'h0, 1);
    run_cmd(8'h03, 8'h40, 8'd0, 32'h0, 0);

    // A second frame waiting while a run is in progress is held off until the report
    expect_cmd(8'h02, 8'h50, 8'd0, 32'h0, 10);
    expect_cmd(8'h00, 8'h51, 8'd0, 32'h0, 0);
    b_sv = sv_cnt;
    b_start = start_cnt;
    present(8'h02, 8'h50, 8'd0, 32'h0);
    wait_start(b_start);
    b_ack = ack_cnt;
    rx.FRAME = make_frame(8'h00, 8'h51, 8'd0, 32'h0);
    rx.FRAME_READY = 1'b1;
    n = 0;
    while (sv_cnt == b_sv && n < T + 10) begin
      DUT_DONE = (n == 10);
      step();
      n++;
    end
    DUT_DONE = 1'b0;
    check("no_ack_while_busy", ack_cnt - b_ack, 0);
    n = 0;
    while (ack_cnt == b_ack && n < 10) begin step(); n++; end
    rx.FRAME_READY = 1'b0;
    check("pending_ack_after_report", ack_cyc - sv_cyc, 1);
    n = 0;
    while (sv_cnt < b_sv + 2 && n < 20) begin step(); n++; end
    step();
    check("one_status_per_frame", sv_cnt - b_sv, 2);

    // Reset during a run drops the frame without a report and clears config
    b_sv = sv_cnt;
    b_start = start_cnt;
    expect_cmd(8'h02, 8'h60, 8'd0, 32'h0, 1000);
    present(8'h02, 8'h60, 8'd0, 32'h0);
    wait_start(b_start);
    repeat (5) step();
    RST_N = 1'b0;
    #1;
    check_reset_outputs("abort");
    void'(exp_q.pop_back());
    for (int i = 0; i < NUM_CFG; i++) model_cfg[i] = '0;
    repeat (3) step();
    RST_N = 1'b1;
    repeat (T + 6) step();
    check("aborted_no_status", sv_cnt - b_sv, 0);
    check("dut_rst_n_after_abort", DUT_RST_N, 1);
    run_cmd(8'h01, 8'h61, 8'd1, 32'hCAFEF00D, 0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: op = 8'h00;
        1: op = 8'h01;
        2: op = 8'h02;
        3: op = 8'h03;
        default: op = 8'($urandom_range(4, 255));
      endcase
      idx = 8'($urandom_range(0, 6));
      d = ($urandom_range(0, 7) == 0) ? 500 : int'($urandom_range(0, T + 3));
      run_cmd(op, 8'($urandom()), idx, $urandom(), d);
    end

    repeat (5) step();
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
